module_serial_rx: RTL and testbench

MODULE_SERIAL_RX -- requirements
Module: module_serial_rx

---
 rtl/module_serial_rx.sv | 140 ++++++++++++++
 tb/tb_module_serial_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/module_serial_rx.sv
// Asynchronous serial receiver: 8N1-style framing with parameterised bit
// period and word width, oversampled at mid-bit, with a valid/ready output
// port, a frame-error pulse on a low stop bit and an overrun pulse when a
// completed word cannot be handed over.
module module_serial_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 sync_p0;
  logic                 sync_p1;
  logic                 line;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  assign line = sync_p1;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
    end
  end

  // Frame FSM plus output register/handshake; reception never waits on ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      out       <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A transfer drops valid unless a new word reloads it below
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!line) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_cnt <= '0;
            // Line back high at mid start bit means it was only a glitch
            state   <= line ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            shreg <= {line, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (line) begin
              state <= IDLE;
              // Slot is free, or is being emptied this very cycle
              if (!valid || ready) begin
                out   <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          // Hold off until a break ends so it yields a single frame error
          if (line) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_module_serial_rx.sv
// Bench for module_serial_rx: table of single frames plus hand-written
// sequences for glitch, break, overrun, same-cycle handoff and mid-frame reset.
module tb_module_serial_rx;

  localparam int CPB = 4;
  localparam int DB  = 8;

  logic          clk;
  logic          rst;
  logic          in_line;
  logic          ready;
  logic [DB-1:0] out;
  logic          valid;
  logic          frame_err;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor tallies
  int words_cnt = 0;
  int ferr_cnt  = 0;
  int ovr_cnt   = 0;
  int vcyc_cnt  = 0;

  logic [DB-1:0] sb[$];

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DB-1:0] prev_out   = '0;

  module_serial_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in_line),
    .out      (out),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Negedge monitor: pulse counting, stall stability and scoreboard pops
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (valid) vcyc_cnt++;
      if (prev_valid && !prev_ready) begin
        check("stall_valid_held", 32'(valid), 32'd1);
        check("stall_out_held", 32'(out), 32'(prev_out));
      end
      if (valid && ready) begin
        check("sb_word_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          check("sb_out", 32'(out), 32'(sb.pop_front()));
        end
        words_cnt++;
      end
      prev_valid = valid;
      prev_ready = ready;
      prev_out   = out;
    end else begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end
  end

  task automatic hold(input logic v, input int n);
    in_line = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int stop_len);
    hold(1'b0, CPB);
    for (int i = 0; i < DB; i++) begin
      hold(d[i], CPB);
    end
    hold(stop, stop_len);
    in_line = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out"}, 32'(out), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    int            exp_words;
    int            exp_ferr;
  } vec_t;

  vec_t vecs[6];

  int b_words, b_ferr, b_ovr, b_vcyc;

  task automatic snap();
    b_words = words_cnt;
    b_ferr  = ferr_cnt;
    b_ovr   = ovr_cnt;
    b_vcyc  = vcyc_cnt;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h5A, 1'b1, 1, 0};
    vecs[4] = '{8'h81, 1'b1, 1, 0};
    vecs[5] = '{8'hC7, 1'b0, 0, 1};

    rst     = 1'b1;
    in_line = 1'b1;
    ready   = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle line after reset: nothing may happen
    snap();
    hold(1'b1, 50);
    check("idle_valid_cycles", 32'(vcyc_cnt - b_vcyc), 32'd0);
    check("idle_ferr", 32'(ferr_cnt - b_ferr), 32'd0);
    check("idle_ovr", 32'(ovr_cnt - b_ovr), 32'd0);
    check("idle_out", 32'(out), 32'd0);

    // Table-driven single frames with a ready consumer
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      snap();
      if (vecs[i].stop) sb.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, CPB);
      hold(1'b1, 3 * CPB);
      check($sformatf("vec%0d_words", i), 32'(words_cnt - b_words), 32'(vecs[i].exp_words));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - b_ferr), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - b_ovr), 32'd0);
      check($sformatf("vec%0d_valid_cycles", i), 32'(vcyc_cnt - b_vcyc), 32'(vecs[i].exp_words));
    end

    // Short low glitch, then a good frame
    snap();
    hold(1'b0, CPB / 2 - 1);
    hold(1'b1, 3 * CPB);
    check("glitch_valid_cycles", 32'(vcyc_cnt - b_vcyc), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt - b_ferr), 32'd0);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1, CPB);
    hold(1'b1, 3 * CPB);
    check("post_glitch_words", 32'(words_cnt - b_words), 32'd1);

    // Break: stop bit low and line held low, then recovery
    snap();
    send_frame(8'h55, 1'b0, 40);
    hold(1'b1, 3 * CPB);
    check("break_ferr", 32'(ferr_cnt - b_ferr), 32'd1);
    check("break_valid_cycles", 32'(vcyc_cnt - b_vcyc), 32'd0);
    sb.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, CPB);
    hold(1'b1, 3 * CPB);
    check("post_break_words", 32'(words_cnt - b_words), 32'd1);
    check("post_break_ferr", 32'(ferr_cnt - b_ferr), 32'd1);

    // Overrun: stalled consumer, two frames back to back
    ready = 1'b0;
    snap();
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, CPB);
    send_frame(8'hC3, 1'b1, CPB);
    hold(1'b1, 3 * CPB);
    check("ovr_pulses", 32'(ovr_cnt - b_ovr), 32'd1);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_out", 32'(out), 32'h3C);
    check("ovr_words_before_ready", 32'(words_cnt - b_words), 32'd0);
    ready = 1'b1;
    hold(1'b1, 2);
    check("ovr_words_after_ready", 32'(words_cnt - b_words), 32'd1);
    check("ovr_valid_after_ready", 32'(valid), 32'd0);

    // Transfer in the same cycle a new word completes
    ready = 1'b0;
    snap();
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, CPB);
    hold(1'b1, 4);
    sb.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1, CPB);
      begin
        repeat (40) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    check("handoff_valid", 32'(valid), 32'd1);
    check("handoff_out", 32'(out), 32'h22);
    check("handoff_ovr", 32'(ovr_cnt - b_ovr), 32'd0);
    ready = 1'b1;
    hold(1'b1, 2);
    check("handoff_words", 32'(words_cnt - b_words), 32'd2);

    // Reset during data bit 4 of 0xFF, then a clean frame
    snap();
    fork
      send_frame(8'hFF, 1'b1, CPB);
      begin
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    hold(1'b1, 3 * CPB);
    check("midrst_no_partial", 32'(words_cnt - b_words), 32'd0);
    sb.push_back(8'h12);
    send_frame(8'h12, 1'b1, CPB);
    hold(1'b1, 3 * CPB);
    check("midrst_words", 32'(words_cnt - b_words), 32'd1);
    check("midrst_ferr", 32'(ferr_cnt - b_ferr), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
